// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and helpers for the dsp sample FIFO read path.
package fifo_stream_reader_pkg;

  localparam int OUTQ_DEPTH    = 3;
  localparam int DEFAULT_WIDTH = 18;
  localparam int FRAME_CNT_W   = 16;
  localparam int OUTQ_CNT_W    = $clog2(OUTQ_DEPTH + 1);

  typedef logic [OUTQ_CNT_W-1:0] outq_cnt_t;

  // A read may only issue if its data is guaranteed a free queue slot on arrival.
  function automatic logic outq_has_room(input outq_cnt_t count, input logic inflight);
    return (int'(count) + int'(inflight)) < OUTQ_DEPTH;
  endfunction

endpackage

// File: rtl/fifo_rd_outq.sv
// Small registered shift queue; entry 0 is the head and drives the stream outputs.
module fifo_rd_outq
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output outq_cnt_t        count
);

  logic [WIDTH-1:0] mem      [OUTQ_DEPTH];
  logic [WIDTH-1:0] mem_next [OUTQ_DEPTH];
  outq_cnt_t        wr_idx;

  // On a simultaneous push/pop the new word lands one slot lower, after the shift.
  always_comb begin
    wr_idx = count - outq_cnt_t'(pop);
    for (int i = 0; i < OUTQ_DEPTH; i++) mem_next[i] = mem[i];
    if (pop) begin
      for (int i = 0; i < OUTQ_DEPTH - 1; i++) mem_next[i] = mem[i + 1];
    end
    for (int i = 0; i < OUTQ_DEPTH; i++) begin
      if (push && int'(wr_idx) == i) mem_next[i] = push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUTQ_DEPTH; i++) mem[i] <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < OUTQ_DEPTH; i++) mem[i] <= mem_next[i];
      count <= count + outq_cnt_t'(push) - outq_cnt_t'(pop);
    end
  end

  assign head_data  = mem[0];
  assign head_valid = (count != '0);

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the dsp sample FIFO into a valid/ready stream with per-frame last flags.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int FRAME_LEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_d_out,
  output logic                   fifo_rd_en,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_last,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   underrun
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  // Stream handshake: a beat moves on a rising edge where m_valid and m_ready are
  // both high; m_valid/m_data/m_last never change while a beat waits for m_ready.
  logic             inflight;
  logic             pop;
  outq_cnt_t        q_count;
  logic [IDX_W-1:0] beat_idx;

  // Only registered state, en and fifo_empty feed the strobe; m_ready never does.
  assign fifo_rd_en = !rst && en && !fifo_empty && outq_has_room(q_count, inflight);
  assign pop        = m_valid && m_ready;
  assign m_last     = m_valid && (beat_idx == LAST_IDX);

  fifo_rd_outq #(.WIDTH(WIDTH)) u_outq (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight),
    .push_data  (fifo_d_out),
    .pop        (pop),
    .head_data  (m_data),
    .head_valid (m_valid),
    .count      (q_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight  <= 1'b0;
      beat_idx  <= '0;
      frame_cnt <= '0;
      underrun  <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop) begin
        if (m_last) begin
          beat_idx  <= '0;
          frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end else begin
          beat_idx <= beat_idx + IDX_W'(1);
        end
      end
      // Sink asked for the next beat of an open frame and nothing was there.
      if (beat_idx != '0 && m_ready && !m_valid) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model, expected-data queue, scenario tasks.
module tb_fifo_stream_reader;

  localparam int W  = 18;
  localparam int FL = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          fifo_empty;
  logic [W-1:0]  fifo_d_out;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic [15:0]   frame_cnt;
  logic          underrun;

  int checks = 0;
  int fails  = 0;

  logic [W-1:0] exp_q[$];
  int           exp_beat = 0;

  logic [W-1:0] fifo_mem [1024];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  int           occ    = 0;

  fifo_stream_reader #(.WIDTH(W), .FRAME_LEN(FL)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_d_out (fifo_d_out),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .frame_cnt  (frame_cnt),
    .underrun   (underrun)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // FIFO model with one-cycle registered read; flushed by the shared reset
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= wr_ptr;
      fifo_d_out <= '0;
    end else if (fifo_rd_en) begin
      fifo_d_out <= fifo_mem[rd_ptr % 1024];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // words issued by the reader and not yet handed to the sink (queue + in flight)
  always @(posedge clk or posedge rst) begin
    if (rst) occ <= 0;
    else     occ <= occ + int'(fifo_rd_en) - int'(m_valid && m_ready);
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic fifo_write(input logic [W-1:0] d);
    fifo_mem[wr_ptr % 1024] = d;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(d);
  endtask

  task automatic preload(input int n);
    for (int i = 1; i <= n; i++) fifo_write(W'(i));
  endtask

  task automatic tick(input logic rdy, output logic xfer);
    @(negedge clk);
    m_ready = rdy;
    xfer = m_valid && m_ready;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_beat = 0;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({fifo_rd_en, m_valid, m_last, underrun} !== 4'b0) begin
      fails++;
      $display("FAIL reset_flags actual rd_en/valid/last/underrun=%b required=0000",
               {fifo_rd_en, m_valid, m_last, underrun});
    end
    checks++;
    if (m_data !== '0) begin
      fails++; $display("FAIL reset_data actual=%h required=0", m_data);
    end
    checks++;
    if (frame_cnt !== 16'd0) begin
      fails++; $display("FAIL reset_frame_cnt actual=%0d required=0", frame_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic xfer;
    logic [W-1:0] ed;
    logic el;
    preload(64);
    en = 1'b1;
    for (int cyc = 0; cyc < 70; cyc++) begin
      tick(1'b1, xfer);
      checks++;
      if (m_valid !== (cyc >= 1 && cyc <= 64)) begin
        fails++; $display("FAIL stream_valid cyc=%0d actual=%b required=%b", cyc, m_valid, (cyc >= 1 && cyc <= 64));
      end
      if (xfer) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL stream_extra actual=%h required=none", m_data);
        end else begin
          ed = exp_q.pop_front(); el = (exp_beat % FL) == FL - 1; exp_beat++;
          if (m_data !== ed || m_last !== el) begin
            fails++;
            $display("FAIL stream_beat actual data=%h last=%b required data=%h last=%b", m_data, m_last, ed, el);
          end
        end
      end
    end
    checks++;
    if (frame_cnt !== 16'd2 || underrun !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL stream_end actual frames=%0d underrun=%b left=%0d required frames=2 underrun=0 left=0",
               frame_cnt, underrun, exp_q.size());
    end
  endtask

  task automatic test_stall();
    logic xfer;
    logic held;
    logic [W-1:0] held_data;
    logic [W-1:0] ed;
    logic el;
    int budget;
    do_reset();
    preload(64);
    en = 1'b1;
    held = 1'b0;
    held_data = '0;
    budget = 0;
    while (exp_q.size() != 0 && budget < 400) begin
      tick((budget % 4 == 0) || (budget % 4 == 3), xfer);
      budget++;
      if (held) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== held_data) begin
          fails++;
          $display("FAIL stall_hold actual valid=%b data=%h required valid=1 data=%h", m_valid, m_data, held_data);
        end
      end
      checks++;
      if (fifo_rd_en && (occ >= 3 || fifo_empty)) begin
        fails++; $display("FAIL stall_rd_en actual rd_en=1 occ=%0d empty=%b required rd_en=0", occ, fifo_empty);
      end
      if (xfer) begin
        checks++;
        ed = exp_q.pop_front(); el = (exp_beat % FL) == FL - 1; exp_beat++;
        if (m_data !== ed || m_last !== el) begin
          fails++;
          $display("FAIL stall_beat actual data=%h last=%b required data=%h last=%b", m_data, m_last, ed, el);
        end
      end
      held = m_valid && !xfer;
      held_data = m_data;
    end
    repeat (4) tick(1'b1, xfer);
    checks++;
    if (exp_q.size() != 0 || frame_cnt !== 16'd2 || xfer) begin
      fails++;
      $display("FAIL stall_end actual left=%0d frames=%0d extra=%b required left=0 frames=2 extra=0",
               exp_q.size(), frame_cnt, xfer);
    end
  endtask

  task automatic test_starve();
    logic xfer;
    logic [W-1:0] ed;
    int beats;
    do_reset();
    en = 1'b1;
    repeat (4) begin
      tick(1'b1, xfer);
      checks++;
      if (m_valid !== 1'b0 || underrun !== 1'b0) begin
        fails++; $display("FAIL starve_idle actual valid=%b underrun=%b required 0 0", m_valid, underrun);
      end
    end
    for (int i = 0; i < 5; i++) fifo_write(W'(32'h100 + i));
    beats = 0;
    repeat (12) begin
      tick(1'b1, xfer);
      if (xfer) begin
        checks++;
        ed = exp_q.size() != 0 ? exp_q.pop_front() : '1;
        exp_beat++;
        beats++;
        if (m_data !== ed || m_last !== 1'b0 || underrun !== 1'b0) begin
          fails++;
          $display("FAIL starve_beat actual data=%h last=%b underrun=%b required data=%h last=0 underrun=0",
                   m_data, m_last, underrun, ed);
        end
      end
    end
    checks++;
    if (beats != 5 || underrun !== 1'b1 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL starve_end actual beats=%0d underrun=%b valid=%b required beats=5 underrun=1 valid=0",
               beats, underrun, m_valid);
    end
  endtask

  task automatic test_en_drop();
    logic xfer;
    logic [W-1:0] ed;
    logic el;
    int after;
    int last_at;
    int budget;
    do_reset();
    preload(40);
    en = 1'b1;
    last_at = -1;
    budget = 0;
    while (exp_beat < 10 && budget < 100) begin
      tick(1'b1, xfer);
      budget++;
      if (xfer) begin
        checks++;
        ed = exp_q.pop_front(); el = (exp_beat % FL) == FL - 1; exp_beat++;
        if (m_data !== ed || m_last !== el) begin
          fails++;
          $display("FAIL endrop_beat actual data=%h last=%b required data=%h last=%b", m_data, m_last, ed, el);
        end
      end
    end
    en = 1'b0;
    after = 0;
    repeat (10) begin
      tick(1'b1, xfer);
      if (xfer) begin
        checks++;
        ed = exp_q.pop_front(); exp_beat++; after++;
        if (m_data !== ed) begin
          fails++; $display("FAIL endrop_drain actual=%h required=%h", m_data, ed);
        end
      end
    end
    checks++;
    if (after > 3) begin
      fails++; $display("FAIL endrop_count actual=%0d required<=3", after);
    end
    en = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      tick(1'b1, xfer);
      budget++;
      if (xfer) begin
        checks++;
        ed = exp_q.pop_front(); el = (exp_beat % FL) == FL - 1; exp_beat++;
        if (m_last) last_at = exp_beat;
        if (m_data !== ed || m_last !== el) begin
          fails++;
          $display("FAIL endrop_resume actual data=%h last=%b required data=%h last=%b", m_data, m_last, ed, el);
        end
      end
    end
    checks++;
    if (last_at != 32 || frame_cnt !== 16'd1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL endrop_end actual last_at=%0d frames=%0d left=%0d required last_at=32 frames=1 left=0",
               last_at, frame_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic xfer;
    logic [W-1:0] ed;
    logic el;
    int last_at;
    int lasts;
    int budget;
    do_reset();
    preload(64);
    en = 1'b1;
    budget = 0;
    xfer = 1'b0;
    while (!(xfer && exp_beat == 16) && budget < 100) begin
      tick(1'b1, xfer);
      budget++;
      if (xfer && exp_beat < 16) begin
        checks++;
        ed = exp_q.pop_front(); exp_beat++;
        if (m_data !== ed) begin
          fails++; $display("FAIL rstmid_pre actual=%h required=%h", m_data, ed);
        end
      end
    end
    checks++;
    if (exp_beat != 16 || m_valid !== 1'b1) begin
      fails++; $display("FAIL rstmid_reach actual beats=%0d valid=%b required beats=16 valid=1", exp_beat, m_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({fifo_rd_en, m_valid, m_last, underrun} !== 4'b0 || m_data !== '0 || frame_cnt !== 16'd0) begin
      fails++;
      $display("FAIL rstmid_async actual rd_en/valid/last/underrun=%b data=%h frames=%0d required 0000 0 0",
               {fifo_rd_en, m_valid, m_last, underrun}, m_data, frame_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_beat = 0;
    preload(40);
    last_at = -1;
    lasts = 0;
    budget = 0;
    while (exp_q.size() != 0 && budget < 400) begin
      tick(1'($urandom_range(0, 1)), xfer);
      budget++;
      if (xfer) begin
        checks++;
        ed = exp_q.pop_front(); el = (exp_beat % FL) == FL - 1; exp_beat++;
        if (m_last) begin last_at = exp_beat; lasts++; end
        if (m_data !== ed || m_last !== el) begin
          fails++;
          $display("FAIL rstmid_beat actual data=%h last=%b required data=%h last=%b", m_data, m_last, ed, el);
        end
      end
    end
    checks++;
    if (last_at != 32 || lasts != 1 || frame_cnt !== 16'd1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL rstmid_end actual last_at=%0d lasts=%0d frames=%0d left=%0d required 32 1 1 0",
               last_at, lasts, frame_cnt, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    m_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_starve();
    test_en_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
